cc1200_spi_sequencer: RTL and testbench
=======================================

# cc1200_spi_sequencer

Command sequencer that sits directly upstream of the CC1200 SPI transaction engine. It accepts CC1200 command words (header byte plus up to 3 data bytes) from a valid/ready stream and drives the engine's Start/DataOut/WR inputs. It tracks the engine's Busy handshake, captures the returned DataIn word and queues it in a response FIFO. Firmware or a DMA path can issue back-to-back register bursts without polling the engine per transaction.

## Interface
- RSP_DEPTH, 4: response FIFO depth in entries; power of two, 2..16.
- TIMEOUT_CYC, 65535: maximum clk cycles per Busy phase before abort; used only with the timeout feature; 16-bit.
- clk  in  1  sequencer and SPI engine clock.
- rstn  in  1  asynchronous active-low reset; clears all state.
- cmd_valid  in  1  command word offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_data  in  32  bits[31:24] first byte sent (header); bits[23:0] following bytes.
- cmd_wr  in  4  byte-enable/length mask passed to the engine as WR.
- Start  out  1  one-cycle transaction start pulse to the engine.
- Busy  in  1  engine busy.
- DataOut  out  32  word to the engine; held stable for the whole transaction.
- WR  out  4  length mask to the engine; held with DataOut.
- DataIn  in  32  word shifted in by the engine.
- rsp_valid  out  1  response FIFO non-empty.
- rsp_ready  in  1  pops the head entry when rsp_valid && rsp_ready.
- rsp_data  out  32  head entry: captured DataIn.
- rsp_err  out  1  head entry tag: transaction aborted by timeout; always 0 when the timeout feature is compiled out.
- seq_busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: cmd_ready = (free slots > 0). On accept, latch cmd_data into DataOut and cmd_wr into WR, then go to LAUNCH.
  - LAUNCH: Start=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: remain until Busy=1, then go to WAIT_DONE.
  - WAIT_DONE: remain until Busy=0, then go to CAPTURE.
  - CAPTURE: push {err, DataIn} into the FIFO, then go to IDLE.
- Slot reservation: a slot is reserved at accept, so CAPTURE never sees a full FIFO. free = RSP_DEPTH − count − (state != IDLE).
- cmd_ready is 0 in every state except IDLE, so only one transaction is outstanding at a time.
- FIFO:
  - Circular buffer with wrapping read and write pointers of log2(RSP_DEPTH) bits, plus a count of log2(RSP_DEPTH)+1 bits.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Pop while empty is ignored.
- DataOut and WR are modified only on command accept. They hold their value after the transaction completes.
- WR=4'h0 is forwarded unchanged. The engine defines the resulting length.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after rstn deasserts. Start=0, DataOut=0, WR=0, rsp_valid=0, rsp_data=0, rsp_err=0, seq_busy=0, FIFO empty, state IDLE.
- Cycle sequence, with accept at cycle T:
  - T+1: Start=1.
  - T+2 onward: WAIT_BUSY.
  - Busy rising seen at cycle B: WAIT_DONE from B+1.
  - Busy low seen at cycle D: CAPTURE at D+1.
  - D+2: entry visible (rsp_valid=1). IDLE at D+2, so the next accept can occur at D+2.
- rsp_data and rsp_err come from registered FIFO storage indexed by the read pointer. The head entry changes the cycle after a pop.
- Busy is sampled only in WAIT_BUSY and WAIT_DONE. Busy activity in other states is ignored.
- Asserting rstn mid-transaction immediately clears Start, the FIFO and the state. The engine is reset by the same rstn.

## Configuration
- CC1200_SEQ_TIMEOUT_EN defined:
  - A 16-bit cycle counter clears on entry to WAIT_BUSY and on entry to WAIT_DONE.
  - If the counter reaches TIMEOUT_CYC in either state, go to CAPTURE and push {1, 32'h00000000} instead of DataIn.
  - The next command is then accepted normally.
- Not defined: no counter exists. WAIT_BUSY and WAIT_DONE wait indefinitely, and rsp_err is tied to 0.

## Test plan
- Single command: cmd_data=32'h2F8F0000, WR=4'h3, Busy model high for 20 cycles starting 2 cycles after Start. Required response:
  - One Start pulse exactly 1 cycle wide.
  - DataOut stable for the whole transaction.
  - rsp_data equals the model's DataIn (32'h0000A55A) at D+2, with rsp_err=0.
- Back-to-back: cmd_valid held high for 3 commands. Required response:
  - The second accept occurs at D+2 of the first transaction.
  - 3 responses are returned in order.
- FIFO full: RSP_DEPTH=4 and rsp_ready=0. Required response:
  - After 4 transactions, cmd_ready stays 0.
  - One pop brings cmd_ready back to 1 in the following cycle.
- Simultaneous push/pop: rsp_ready=1 continuously during a 5-command burst. Required response:
  - count never exceeds 1.
  - No entry is lost or duplicated.
- Reset mid-transaction: drop rstn during WAIT_DONE. Required response:
  - All outputs return to reset values immediately.
  - The FIFO is empty after release.
- Timeout (CC1200_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100): Busy never asserts. Required response:
  - A response with rsp_err=1 and rsp_data=0 is returned 100 cycles after entry to WAIT_BUSY.
  - The next command completes normally.

Source files
------------

// File: rtl/cc1200_spi_sequencer.sv
// Command sequencer feeding the CC1200 SPI engine: one outstanding transaction, responses queued in a small FIFO.
// Optional Busy-phase timeout/abort is compiled in with `define CC1200_SEQ_TIMEOUT_EN.
module cc1200_spi_sequencer #(
   parameter int          RSP_DEPTH   = 4,
   parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_data,
   input  logic [3:0]  cmd_wr,
   output logic        Start,
   input  logic        Busy,
   output logic [31:0] DataOut,
   output logic [3:0]  WR,
   input  logic [31:0] DataIn,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        seq_busy
);

   localparam int          AW      = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(RSP_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_CAPTURE
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   dout_q;
   logic [3:0]    wr_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic [31:0]   mem_q [RSP_DEPTH];
   logic          accept, push, pop;
   logic [31:0]   push_data;

   // Outside IDLE one slot is already reserved for the in-flight response,
   // so IDLE only needs a non-full FIFO to take another command.
   assign cmd_ready = rstn && (state_q == S_IDLE) && (count_q != DEPTH_C);
   assign accept    = cmd_valid && cmd_ready;
   assign push      = (state_q == S_CAPTURE);
   assign rsp_valid = (count_q != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign Start     = (state_q == S_LAUNCH);
   assign seq_busy  = (state_q != S_IDLE);
   assign DataOut   = dout_q;
   assign WR        = wr_q;
   assign rsp_data  = mem_q[rd_ptr_q];

`ifdef CC1200_SEQ_TIMEOUT_EN
   logic [15:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;
   logic        tmo_hit;
   logic        err_q, err_d;
   logic        err_mem_q [RSP_DEPTH];

   assign tmo_inc = tmo_cnt_q + 16'd1;
   // A Busy transition wins over an expiring counter in the same cycle.
   assign tmo_hit = (((state_q == S_WAIT_BUSY) && !Busy) ||
                     ((state_q == S_WAIT_DONE) && Busy)) && (tmo_inc == TIMEOUT_CYC);

   always_comb begin
      tmo_cnt_d = 16'd0;
      if ((state_q == state_d) && ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE))) begin
         tmo_cnt_d = tmo_inc;
      end
   end

   always_comb begin
      err_d = err_q;
      if (accept) begin
         err_d = 1'b0;
      end else if (tmo_hit) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tmo_cnt_q <= 16'd0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end

   assign push_data = err_q ? 32'h0000_0000 : DataIn;
   assign rsp_err   = err_mem_q[rd_ptr_q];
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign push_data          = DataIn;
   assign rsp_err            = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (accept) state_d = S_LAUNCH;
         S_LAUNCH:    state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: if (Busy) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (!Busy) state_d = S_CAPTURE;
         S_CAPTURE:   state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
`ifdef CC1200_SEQ_TIMEOUT_EN
      if (tmo_hit) state_d = S_CAPTURE;
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         dout_q   <= 32'h0000_0000;
         wr_q     <= 4'h0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            dout_q <= cmd_data;
            wr_q   <= cmd_wr;
         end
         if (push) wr_ptr_q <= wr_ptr_q + (AW)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW)'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is cleared by reset so the head reads zero while the FIFO is empty after reset.
   for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            mem_q[gi] <= 32'h0000_0000;
         end else if (push && (wr_ptr_q == (AW)'(gi))) begin
            mem_q[gi] <= push_data;
         end
      end
`ifdef CC1200_SEQ_TIMEOUT_EN
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            err_mem_q[gi] <= 1'b0;
         end else if (push && (wr_ptr_q == (AW)'(gi))) begin
            err_mem_q[gi] <= err_q;
         end
      end
`endif
   end

endmodule

// File: tb/tb_cc1200_spi_sequencer.sv
// Directed self-checking bench for cc1200_spi_sequencer with a simple Busy/DataIn engine model.
module tb_cc1200_spi_sequencer;

   logic        clk;
   logic        rstn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_data;
   logic [3:0]  cmd_wr;
   logic        Start;
   logic        Busy;
   logic [31:0] DataOut;
   logic [3:0]  WR;
   logic [31:0] DataIn;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        seq_busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // engine model controls
   int          busy_delay = 2;
   int          busy_len   = 20;
   bit          eng_mute   = 0;
   int          eng_t      = -1;
   logic [31:0] din_q [$];

   // driver records
   int          acc_cyc [8];
   logic [31:0] rx [8];
   int          nrx;
   int          consec_valid;
   bit          drv_done;

   cc1200_spi_sequencer #(
      .RSP_DEPTH   (4),
      .TIMEOUT_CYC (16'd100)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_wr    (cmd_wr),
      .Start     (Start),
      .Busy      (Busy),
      .DataOut   (DataOut),
      .WR        (WR),
      .DataIn    (DataIn),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .seq_busy  (seq_busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Engine: Busy high for busy_len cycles starting busy_delay cycles after the Start cycle.
   always @(negedge clk) begin
      if (!rstn) begin
         eng_t = -1;
         Busy  = 1'b0;
      end else begin
         if (Start) begin
            eng_t  = 0;
            DataIn = (din_q.size() > 0) ? din_q.pop_front() : 32'h0;
         end else if (eng_t >= 0) begin
            eng_t++;
         end
         Busy = !eng_mute && (eng_t >= busy_delay) && (eng_t < busy_delay + busy_len);
         if (eng_t > busy_delay + busy_len) eng_t = -1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Streams num commands (cmd_data = base + i) back-to-back; collects responses when rsp_ready is high.
   task automatic drive_cmds(input int num, input logic [31:0] base);
      bit acc_prev;
      bit prev_valid;
      int n;
      n = 0; acc_prev = 0; prev_valid = 0; nrx = 0; consec_valid = 0;
      cmd_data = base; cmd_wr = 4'h1; cmd_valid = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         if (acc_prev) begin
            if (n < num) begin
               cmd_data = base + 32'(n);
               cmd_wr   = 4'(n + 1);
            end else begin
               cmd_valid = 1'b0;
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (prev_valid) consec_valid++;
            if (nrx < 8) rx[nrx] = rsp_data;
            nrx++;
         end
         prev_valid = rsp_valid && rsp_ready;
         acc_prev   = cmd_valid && cmd_ready;
         if (acc_prev) begin
            if (n < 8) acc_cyc[n] = cyc;
            n++;
         end
         if (n == num && !acc_prev && !seq_busy) break;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      drv_done  = (n == num) && !seq_busy;
   endtask

   task automatic test_reset();
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
      checks++; if (Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", Start); end
      checks++; if (DataOut !== 32'h0 || WR !== 4'h0) begin errors++; $display("FAIL reset_dataout_wr: got %h/%h expected 0/0", DataOut, WR); end
      checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got v=%b d=%h e=%b expected 0/0/0", rsp_valid, rsp_data, rsp_err); end
      checks++; if (seq_busy !== 1'b0) begin errors++; $display("FAIL reset_seq_busy: got %b expected 0", seq_busy); end
      rstn = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
      @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_single();
      int t_acc, t_vis, starts;
      bit seen, unstable;
      busy_delay = 2; busy_len = 20; rsp_ready = 1'b0;
      din_q.push_back(32'h0000A55A);
      cmd_data = 32'h2F8F0000; cmd_wr = 4'h3; cmd_valid = 1'b1;
      t_acc = cyc;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0; cmd_data = 32'hFFFFFFFF; cmd_wr = 4'hF;
      checks++; if (Start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", Start); end
      checks++; if (DataOut !== 32'h2F8F0000 || WR !== 4'h3) begin errors++; $display("FAIL single_latch: got %h/%h expected 2f8f0000/3", DataOut, WR); end
      starts = 1; seen = 0; unstable = 0; t_vis = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (Start) starts++;
         if (DataOut !== 32'h2F8F0000 || WR !== 4'h3) unstable = 1;
         if (rsp_valid) begin t_vis = cyc; seen = 1; break; end
      end
      checks++; if (starts != 1) begin errors++; $display("FAIL single_start_pulses: got %0d expected 1", starts); end
      checks++; if (unstable) begin errors++; $display("FAIL single_dataout_stable: got changed expected stable"); end
      checks++; if (!seen || (t_vis - t_acc) != 25) begin errors++; $display("FAIL single_latency: got %0d expected 25 (seen=%0d)", t_vis - t_acc, seen); end
      checks++; if (rsp_data !== 32'h0000A55A || rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp: got %h/%b expected 0000a55a/0", rsp_data, rsp_err); end
      checks++; if (seq_busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL single_idle: got busy=%b ready=%b expected 0/1", seq_busy, cmd_ready); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b expected 0", rsp_valid); end
      checks++; if (DataOut !== 32'h2F8F0000) begin errors++; $display("FAIL single_hold: got %h expected 2f8f0000", DataOut); end
      $display("test_single done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [3];
      exp = '{32'hB2B00001, 32'hB2B00002, 32'hB2B00003};
      busy_delay = 2; busy_len = 20; rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) din_q.push_back(exp[i]);
      drive_cmds(3, 32'h30000000);
      checks++; if (!drv_done) begin errors++; $display("FAIL b2b_done: got 0 expected 1"); end
      checks++; if (acc_cyc[1] - acc_cyc[0] != 25 || acc_cyc[2] - acc_cyc[1] != 25) begin errors++; $display("FAIL b2b_accept_gap: got %0d,%0d expected 25,25", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
      checks++; if (DataOut !== 32'h30000002 || WR !== 4'h3) begin errors++; $display("FAIL b2b_last_cmd: got %h/%h expected 30000002/3", DataOut, WR); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp[i]) begin errors++; $display("FAIL b2b_rsp%0d: got v=%b %h expected 1 %h", i, rsp_valid, rsp_data, exp[i]); end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
      end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", rsp_valid); end
      $display("test_back_to_back done");
   endtask

   task automatic test_fifo_full();
      bit ready_seen;
      int npop;
      busy_delay = 1; busy_len = 2; rsp_ready = 1'b0;
      din_q.push_back(32'hF0000001); din_q.push_back(32'hF0000002);
      din_q.push_back(32'hF0000003); din_q.push_back(32'hF0000004);
      din_q.push_back(32'hF0000005);
      drive_cmds(4, 32'h40000000);
      checks++; if (!drv_done || cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got done=%0d ready=%b expected 1/0", drv_done, cmd_ready); end
      cmd_data = 32'h40000004; cmd_wr = 4'h5; cmd_valid = 1'b1;
      ready_seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (cmd_ready) ready_seen = 1;
      end
      checks++; if (ready_seen) begin errors++; $display("FAIL full_ready_stays_low: got 1 expected 0"); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b expected 1", cmd_ready); end
      checks++; if (rsp_data !== 32'hF0000002) begin errors++; $display("FAIL full_head_after_pop: got %h expected f0000002", rsp_data); end
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (!seq_busy) break;
         @(negedge clk);
      end
      rsp_ready = 1'b1; npop = 0;
      for (int c = 0; c < 20; c++) begin
         if (!rsp_valid) break;
         npop++;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      checks++; if (npop != 4) begin errors++; $display("FAIL full_drain_count: got %0d expected 4", npop); end
      $display("test_fifo_full done");
   endtask

   task automatic test_push_pop();
      logic [31:0] exp [5];
      exp = '{32'h0000C001, 32'h0000C002, 32'h0000C003, 32'h0000C004, 32'h0000C005};
      busy_delay = 1; busy_len = 2; rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) din_q.push_back(exp[i]);
      drive_cmds(5, 32'h50000000);
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (nrx != 5) begin errors++; $display("FAIL pushpop_count: got %0d expected 5", nrx); end
      checks++; if (consec_valid != 0) begin errors++; $display("FAIL pushpop_occupancy: got %0d back-to-back entries expected 0", consec_valid); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (rx[i] !== exp[i]) begin errors++; $display("FAIL pushpop_rsp%0d: got %h expected %h", i, rx[i], exp[i]); end
      end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty: got %b expected 0", rsp_valid); end
      $display("test_push_pop done");
   endtask

   task automatic test_reset_mid();
      busy_delay = 2; busy_len = 20; rsp_ready = 1'b0;
      din_q.push_back(32'h60000001);
      drive_cmds(1, 32'h60000000);
      din_q.push_back(32'h60000002);
      cmd_data = 32'h6A6A6A6A; cmd_wr = 4'hF; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (seq_busy !== 1'b1 || rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got busy=%b valid=%b expected 1/1", seq_busy, rsp_valid); end
      rstn = 1'b0;
      #1;
      checks++; if (Start !== 1'b0 || seq_busy !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got start=%b busy=%b ready=%b expected 0/0/0", Start, seq_busy, cmd_ready); end
      checks++; if (DataOut !== 32'h0 || WR !== 4'h0) begin errors++; $display("FAIL rstmid_dataout: got %h/%h expected 0/0", DataOut, WR); end
      checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rstmid_rsp: got v=%b d=%h e=%b expected 0/0/0", rsp_valid, rsp_data, rsp_err); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || seq_busy !== 1'b0) begin errors++; $display("FAIL rstmid_release: got v=%b ready=%b busy=%b expected 0/1/0", rsp_valid, cmd_ready, seq_busy); end
      $display("test_reset_mid done");
   endtask

`ifdef CC1200_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int t_acc, t_vis;
      bit seen;
      eng_mute = 1; busy_delay = 2; busy_len = 20; rsp_ready = 1'b0;
      din_q.push_back(32'hDEADBEEF);
      cmd_data = 32'h71000000; cmd_wr = 4'h1; cmd_valid = 1'b1;
      t_acc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
      seen = 0; t_vis = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (rsp_valid) begin t_vis = cyc; seen = 1; break; end
      end
      checks++; if (!seen || (t_vis - t_acc) != 103) begin errors++; $display("FAIL timeout_latency: got %0d expected 103 (seen=%0d)", t_vis - t_acc, seen); end
      checks++; if (rsp_err !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL timeout_rsp: got %h/%b expected 00000000/1", rsp_data, rsp_err); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      eng_mute = 0;
      din_q.push_back(32'h0000600D);
      drive_cmds(1, 32'h70000000);
      checks++; if (!drv_done || rsp_data !== 32'h0000600D || rsp_err !== 1'b0) begin errors++; $display("FAIL timeout_next: got %h/%b expected 0000600d/0", rsp_data, rsp_err); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      $display("test_timeout done");
   endtask
`endif

   initial begin
      rstn = 1'b0; cmd_valid = 1'b0; cmd_data = 32'h0; cmd_wr = 4'h0;
      rsp_ready = 1'b0; Busy = 1'b0; DataIn = 32'h0;
      @(negedge clk);
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_fifo_full();
      test_push_pop();
      test_reset_mid();
`ifdef CC1200_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
